// File: rtl/datapath.sv
// Single-bus CPU datapath: register file slice, PC, IR, MAR/MDR, input port and 64-bit ALU/Z.
// Latency: bus and ALU are combinational; every register loads on the next rising clk edge.
// Backpressure: none. Strobes act unconditionally each cycle; synchronous reset overrides them all.
//
// Optional feature: define DATAPATH_MUL_EN to build the signed 32x32->64 multiplier (ALU code 01011).
// Without it, code 01011 returns 0 and no multiplier is instantiated.
//
// Ports:
//   clk, reset                       clock and synchronous active-high clear
//   r2_in/r4_in/r5_in, r2out/r4out   general register load / drive strobes
//   PC_in, PCout, Inc_PC             PC load / drive / increment (load wins over increment)
//   read, MDR_in, MDRout, MdataIn    MDR source select (1 = memory, 0 = bus), load, drive, memory data
//   IR_in, Y_in, MAR_in              load IR / Y (ALU A operand) / MAR from bus
//   Z_in, ZLOWout                    capture 64-bit ALU result, drive Z[31:0] onto bus
//   inPort_in, inPortout, in_port_data  latch and drive the external input port
//   ALU_select                       5-bit operation code
//   bus                              current bus value
//   ir_q, mar_q, pc_q, r5_q, zhi_q, zlo_q  register observation
module datapath (
   input  logic        clk,
   input  logic        reset,
   input  logic        r2_in,
   input  logic        r4_in,
   input  logic        r5_in,
   input  logic        r2out,
   input  logic        r4out,
   input  logic        PC_in,
   input  logic        PCout,
   input  logic        Inc_PC,
   input  logic        read,
   input  logic        IR_in,
   input  logic        Y_in,
   input  logic        MAR_in,
   input  logic        MDR_in,
   input  logic        Z_in,
   input  logic        ZLOWout,
   input  logic        MDRout,
   input  logic        inPort_in,
   input  logic        inPortout,
   input  logic [4:0]  ALU_select,
   input  logic [31:0] MdataIn,
   input  logic [31:0] in_port_data,
   output logic [31:0] bus,
   output logic [31:0] ir_q,
   output logic [31:0] mar_q,
   output logic [31:0] pc_q,
   output logic [31:0] r5_q,
   output logic [31:0] zhi_q,
   output logic [31:0] zlo_q
);

   localparam logic [4:0] OP_INC = 5'b00000;
   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_AND = 5'b00100;
   localparam logic [4:0] OP_OR  = 5'b00101;
   localparam logic [4:0] OP_SUB = 5'b00110;
   localparam logic [4:0] OP_SHR = 5'b00111;
   localparam logic [4:0] OP_SHL = 5'b01000;
   localparam logic [4:0] OP_ROR = 5'b01001;
   localparam logic [4:0] OP_ROL = 5'b01010;
`ifdef DATAPATH_MUL_EN
   localparam logic [4:0] OP_MUL = 5'b01011;
`endif
   localparam logic [4:0] OP_NEG = 5'b01100;
   localparam logic [4:0] OP_NOT = 5'b01101;

   logic [31:0] r2, r4, r5, pc, ir, y, mar, mdr, inport;
   logic [63:0] z;
   logic [63:0] alu_res;
   logic [4:0]  sh;
   logic [5:0]  sh_inv;

   // Bus mux: every source is a register, so a register that both drives and
   // loads the bus captures its own pre-edge value and no loop can form.
   always_comb begin
      bus = 32'd0;
      if (MDRout)
         bus = mdr;
      else if (ZLOWout)
         bus = z[31:0];
      else if (PCout)
         bus = pc;
      else if (r2out)
         bus = r2;
      else if (r4out)
         bus = r4;
      else if (inPortout)
         bus = inport;
   end

   // Rotate amount and its complement; a zero amount makes the complementary
   // shift 32, which yields 0 and leaves the rotate equal to the input.
   assign sh     = y[4:0];
   assign sh_inv = 6'd32 - {1'b0, sh};

`ifdef DATAPATH_MUL_EN
   logic [63:0] a_ext, b_ext, mul_res;
   // Sign-extending both operands to 64 bits makes the low 64 bits of an
   // unsigned product equal the signed 32x32 product.
   assign a_ext   = {{32{y[31]}}, y};
   assign b_ext   = {{32{bus[31]}}, bus};
   assign mul_res = a_ext * b_ext;
`endif

   always_comb begin
      alu_res = 64'd0;
      case (ALU_select)
         OP_INC: alu_res = {32'd0, bus + 32'd1};
         OP_ADD: alu_res = {32'd0, y + bus};
         OP_AND: alu_res = {32'd0, y & bus};
         OP_OR:  alu_res = {32'd0, y | bus};
         OP_SUB: alu_res = {32'd0, y - bus};
         OP_SHR: alu_res = {32'd0, bus >> sh};
         OP_SHL: alu_res = {32'd0, bus << sh};
         OP_ROR: alu_res = {32'd0, (bus >> sh) | (bus << sh_inv)};
         OP_ROL: alu_res = {32'd0, (bus << sh) | (bus >> sh_inv)};
`ifdef DATAPATH_MUL_EN
         OP_MUL: alu_res = mul_res;
`endif
         OP_NEG: alu_res = {32'd0, 32'd0 - bus};
         OP_NOT: alu_res = {32'd0, ~bus};
         default: alu_res = 64'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r2     <= 32'd0;
         r4     <= 32'd0;
         r5     <= 32'd0;
         pc     <= 32'd0;
         ir     <= 32'd0;
         y      <= 32'd0;
         mar    <= 32'd0;
         mdr    <= 32'd0;
         inport <= 32'd0;
         z      <= 64'd0;
      end else begin
         if (r2_in)     r2     <= bus;
         if (r4_in)     r4     <= bus;
         if (r5_in)     r5     <= bus;
         if (IR_in)     ir     <= bus;
         if (Y_in)      y      <= bus;
         if (MAR_in)    mar    <= bus;
         if (MDR_in)    mdr    <= read ? MdataIn : bus;
         if (inPort_in) inport <= in_port_data;
         if (Z_in)      z      <= alu_res;
         // Explicit load beats increment; the increment wraps naturally at 2^32.
         if (PC_in)
            pc <= bus;
         else if (Inc_PC)
            pc <= pc + 32'd1;
      end
   end

   assign ir_q  = ir;
   assign mar_q = mar;
   assign pc_q  = pc;
   assign r5_q  = r5;
   assign zhi_q = z[63:32];
   assign zlo_q = z[31:0];

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: table of ALU vectors plus directed register-transfer sequences.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled before the next edge.
// Backpressure: none; the bench simply steps the clock.
module tb_datapath;

   logic        clk;
   logic        reset;
   logic        r2_in, r4_in, r5_in, r2out, r4out;
   logic        PC_in, PCout, Inc_PC, read;
   logic        IR_in, Y_in, MAR_in, MDR_in, Z_in, ZLOWout, MDRout;
   logic        inPort_in, inPortout;
   logic [4:0]  ALU_select;
   logic [31:0] MdataIn, in_port_data;
   logic [31:0] bus, ir_q, mar_q, pc_q, r5_q, zhi_q, zlo_q;

   int total = 0;
   int bad   = 0;

   datapath dut (
      .clk(clk), .reset(reset),
      .r2_in(r2_in), .r4_in(r4_in), .r5_in(r5_in),
      .r2out(r2out), .r4out(r4out),
      .PC_in(PC_in), .PCout(PCout), .Inc_PC(Inc_PC), .read(read),
      .IR_in(IR_in), .Y_in(Y_in), .MAR_in(MAR_in), .MDR_in(MDR_in),
      .Z_in(Z_in), .ZLOWout(ZLOWout), .MDRout(MDRout),
      .inPort_in(inPort_in), .inPortout(inPortout),
      .ALU_select(ALU_select), .MdataIn(MdataIn), .in_port_data(in_port_data),
      .bus(bus), .ir_q(ir_q), .mar_q(mar_q), .pc_q(pc_q), .r5_q(r5_q),
      .zhi_q(zhi_q), .zlo_q(zlo_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } alu_vec_t;

   alu_vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_ctl();
      reset = 0;
      r2_in = 0; r4_in = 0; r5_in = 0; r2out = 0; r4out = 0;
      PC_in = 0; PCout = 0; Inc_PC = 0; read = 0;
      IR_in = 0; Y_in = 0; MAR_in = 0; MDR_in = 0;
      Z_in = 0; ZLOWout = 0; MDRout = 0;
      inPort_in = 0; inPortout = 0;
      ALU_select = 5'd0;
   endtask

   // Advance one rising edge, then leave 1 time unit so samples sit away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put_port(input logic [31:0] v);
      in_port_data = v;
      inPort_in    = 1;
      step();
      inPort_in    = 0;
   endtask

   initial begin
      // ALU vectors: {op, A (Y), B (bus), expected Z hi, expected Z lo}
      vecs[0]  = '{5'b00000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000};
      vecs[1]  = '{5'b00000, 32'h0000_0000, 32'h0000_0005, 32'h0, 32'h0000_0006};
      vecs[2]  = '{5'b00011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0000_0001};
      vecs[3]  = '{5'b00100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0000_F000};
      vecs[4]  = '{5'b00101, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 32'h0000_FFF0};
      vecs[5]  = '{5'b00110, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'hFFFF_FFFE};
      vecs[6]  = '{5'b00111, 32'h0000_0024, 32'h8000_0000, 32'h0, 32'h0800_0000};
      vecs[7]  = '{5'b01000, 32'h0000_0008, 32'h1234_5678, 32'h0, 32'h3456_7800};
      vecs[8]  = '{5'b01001, 32'h0000_0004, 32'h1234_5678, 32'h0, 32'h8123_4567};
      vecs[9]  = '{5'b01001, 32'h0000_0000, 32'h1234_5678, 32'h0, 32'h1234_5678};
      vecs[10] = '{5'b01010, 32'h0000_0004, 32'h1234_5678, 32'h0, 32'h2345_6781};
`ifdef DATAPATH_MUL_EN
      vecs[11] = '{5'b01011, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[12] = '{5'b01011, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
`else
      vecs[11] = '{5'b01011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0};
      vecs[12] = '{5'b01011, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0};
`endif
      vecs[13] = '{5'b01100, 32'h0000_0000, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF};
      vecs[14] = '{5'b01101, 32'h0000_0000, 32'h0F0F_0F0F, 32'h0, 32'hF0F0_F0F0};
      vecs[15] = '{5'b11111, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0};

      clear_ctl();
      MdataIn = 32'd0;
      in_port_data = 32'd0;

      // Reset state
      reset = 1;
      step();
      step();
      reset = 0;
      #1;
      check("reset_bus", bus, 32'h0);
      check("reset_pc", pc_q, 32'h0);
      check("reset_zlo", zlo_q, 32'h0);

      // ALU table: load Y via input port, present B on the bus, capture Z
      for (int i = 0; i < 16; i++) begin
         put_port(vecs[i].a);
         inPortout = 1; Y_in = 1;
         step();
         inPortout = 0; Y_in = 0;
         put_port(vecs[i].b);
         inPortout = 1; ALU_select = vecs[i].op; Z_in = 1;
         step();
         clear_ctl();
         check($sformatf("alu%0d_hi", i), zhi_q, vecs[i].hi);
         check($sformatf("alu%0d_lo", i), zlo_q, vecs[i].lo);
      end

      // Register loads from memory through MDR
      MdataIn = 32'h22; read = 1; MDR_in = 1; step(); clear_ctl();
      MDRout = 1; r2_in = 1; step(); clear_ctl();
      MdataIn = 32'h24; read = 1; MDR_in = 1; step(); clear_ctl();
      MDRout = 1; r4_in = 1; step(); clear_ctl();
      MdataIn = 32'h26; read = 1; MDR_in = 1; step(); clear_ctl();
      MDRout = 1; r5_in = 1; step(); clear_ctl();
      r2out = 1; #1; check("r2_load", bus, 32'h22); r2out = 0;
      r4out = 1; #1; check("r4_load", bus, 32'h24); r4out = 0;
      check("r5_load", r5_q, 32'h26);

      // AND of R2 and R4 into R5
      r2out = 1; Y_in = 1; step(); clear_ctl();
      r4out = 1; ALU_select = 5'b00100; Z_in = 1; step(); clear_ctl();
      ZLOWout = 1; r5_in = 1; step(); clear_ctl();
      check("and_r5", r5_q, 32'h20);

      // MDR with read=0 loads from the bus
      r4out = 1; MDR_in = 1; read = 0; MdataIn = 32'hDEAD_BEEF; step(); clear_ctl();
      MDRout = 1; #1; check("mdr_from_bus", bus, 32'h24); MDRout = 0;

      // Fetch increment from PC=0
      PCout = 1; MAR_in = 1; Z_in = 1; ALU_select = 5'b00000; step(); clear_ctl();
      ZLOWout = 1; PC_in = 1; step(); clear_ctl();
      check("fetch_mar", mar_q, 32'h0);
      check("fetch_pc", pc_q, 32'h1);

      // IR load
      put_port(32'hA5A5_0001);
      inPortout = 1; IR_in = 1; step(); clear_ctl();
      check("ir_load", ir_q, 32'hA5A5_0001);

      // PC wrap on increment, then load priority over increment
      put_port(32'hFFFF_FFFF);
      inPortout = 1; PC_in = 1; step(); clear_ctl();
      Inc_PC = 1; step(); clear_ctl();
      check("pc_wrap", pc_q, 32'h0);
      put_port(32'h0000_0040);
      inPortout = 1; PC_in = 1; Inc_PC = 1; step(); clear_ctl();
      check("pc_load_prio", pc_q, 32'h40);

      // Z feeding itself through the incrementer advances exactly once per edge
      ZLOWout = 1; Z_in = 1; ALU_select = 5'b00000;
      step();
      check("z_selfinc1", zlo_q, 32'h0000_0002);
      step();
      clear_ctl();
      check("z_selfinc2", zlo_q, 32'h0000_0003);

      // Bus priority: MDR beats PC, Z beats PC, PC beats R2
      MDRout = 1; PCout = 1; #1; check("prio_mdr_pc", bus, 32'h24); clear_ctl();
      ZLOWout = 1; PCout = 1; #1; check("prio_z_pc", bus, 32'h3); clear_ctl();
      PCout = 1; r2out = 1; inPortout = 1; #1; check("prio_pc_r2", bus, 32'h40); clear_ctl();

      // Reset mid-sequence overrides active strobes
      reset = 1; Inc_PC = 1; ZLOWout = 1; Z_in = 1; r5_in = 1;
      step();
      clear_ctl();
      check("rst_ir", ir_q, 32'h0);
      check("rst_mar", mar_q, 32'h0);
      check("rst_pc", pc_q, 32'h0);
      check("rst_r5", r5_q, 32'h0);
      check("rst_zhi", zhi_q, 32'h0);
      check("rst_zlo", zlo_q, 32'h0);
      check("rst_bus", bus, 32'h0);
      MDRout = 1; #1; check("rst_mdr", bus, 32'h0); clear_ctl();
      r2out = 1; #1; check("rst_r2", bus, 32'h0); clear_ctl();
      inPortout = 1; #1; check("rst_inport", bus, 32'h0); clear_ctl();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high clear
- r2_in, r4_in, r5_in  in  1  load R2/R4/R5 from bus
- r2out, r4out  in  1  drive R2/R4 onto bus
- PC_in  in  1  load PC from bus
- PCout  in  1  drive PC onto bus
- Inc_PC  in  1  PC <= PC+1
- read  in  1  MDR source select: 1 = MdataIn, 0 = bus
- IR_in, Y_in, MAR_in, MDR_in  in  1  load IR/Y/MAR/MDR
- Z_in  in  1  load 64-bit Z from ALU
- ZLOWout  in  1  drive Z[31:0] onto bus
- MDRout  in  1  drive MDR onto bus
- inPort_in  in  1  latch in_port_data into InPort
- inPortout  in  1  drive InPort onto bus
- ALU_select  in  5  ALU operation code
- MdataIn  in  32  memory read data
- in_port_data  in  32  external input-port data
- bus  out  32  current bus value
- ir_q, mar_q, pc_q, r5_q  out  32  register observation
- zhi_q, zlo_q  out  32  Z[63:32], Z[31:0]

Function
REQ-003 The bus SHALL be combinational, with driver priority MDRout > ZLOWout > PCout > r2out > r4out > inPortout, and 0 when no out strobe is asserted.
REQ-004 All registers SHALL update only on the rising clk edge, so a value loaded in cycle N is visible on the bus in cycle N+1.
REQ-005 R2, R4, R5, IR, Y, MAR and PC SHALL each load the bus value when their load strobe is high and hold otherwise.
REQ-006 MDR SHALL load (read ? MdataIn : bus) when MDR_in=1, and hold otherwise.
REQ-007 PC_in SHALL take priority over Inc_PC; with Inc_PC alone, PC SHALL wrap from 0xFFFFFFFF to 0.
REQ-008 The ALU SHALL be combinational with A=Y and B=bus, and SHALL produce a 64-bit result; except for MUL, the upper 32 bits SHALL be 0.
REQ-009 ALU_select codes SHALL be as follows; any other code SHALL give a result of 0.
- 00000: B+1 (increment)
- 00011: A+B (mod 2^32)
- 00100: A AND B
- 00101: A OR B
- 00110: A-B (mod 2^32)
- 00111: B>>A[4:0], logical
- 01000: B<<A[4:0]
- 01001: B rotated right by A[4:0]
- 01010: B rotated left by A[4:0]
- 01011: MUL, signed A*B giving a 64-bit result
- 01100: 0-B
- 01101: NOT B
REQ-010 When Z_in=1, Z SHALL capture the full 64-bit ALU result.
REQ-011 When a register is both a source and a load target in the same cycle, it SHALL capture the pre-edge bus value; there SHALL be no combinational loop.

Reset
REQ-012 When reset=1 at a rising edge, all registers (R2, R4, R5, PC, IR, Y, Z, MAR, MDR, InPort) SHALL clear to 0, overriding every strobe.
REQ-013 Reset applied mid-sequence SHALL take effect at the next edge, and the bus SHALL then read 0 unless a strobe is active.

Configuration
REQ-014 When the macro DATAPATH_MUL_EN is defined, code 01011 SHALL perform the signed 32x32->64 multiply.
REQ-015 When DATAPATH_MUL_EN is undefined, code 01011 SHALL yield 0, and no multiplier logic SHALL be present.

Verification
REQ-016 Register loads: MdataIn=0x22 with read=1 and MDR_in=1, then MDRout=1 and r2_in=1 -> R2 holds 0x22; repeat for R4=0x24 and R5=0x26.
REQ-017 AND: with R2=0x22 and R4=0x24, drive r2out+Y_in, then r4out+ALU_select=00100+Z_in, then ZLOWout+r5_in -> r5_q=0x20.
REQ-018 Fetch increment: with PC=0, drive PCout+MAR_in+Z_in with ALU_select=00000, then ZLOWout+PC_in -> mar_q=0 and pc_q=1.
REQ-019 MUL (macro defined): Y=0xFFFFFFFF and bus=2 with code 01011 and Z_in -> zhi_q=0xFFFFFFFF and zlo_q=0xFFFFFFFE; with the macro undefined -> both 0.
REQ-020 Reset and priority: MDRout and PCout asserted together -> bus=MDR; then reset=1 after loads -> all *_q outputs read 0 on the next cycle.
